shift_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its mode select `S[2:0]` and parallel-load data `L[0:3]`. Accepts multi-step shift commands over a valid/ready handshake and buffers them in a 2-entry FIFO. Expands each command into a cycle-by-cycle stream of select codes, so the shifter performs a load and/or N shifts with no per-cycle control from the host.

---
 rtl/shift_sequencer.sv | 179 +++++++++++++++++
 tb/tb_shift_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: buffers multi-step shift commands in a small FIFO and
// expands each one into a contiguous per-cycle stream of select codes (S)
// and load data (L) for a 4-bit universal shift register.
module shift_sequencer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_count,
  input  logic [0:3] cmd_data,
  output logic [2:0] S,
  output logic [0:3] L,
  output logic       busy,
  output logic       done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] SEL_HOLD = 3'b000;
  localparam logic [2:0] SEL_LOAD = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    LOADSTEP,
    SHIFTSTEP
  } state_t;

  typedef struct packed {
    logic       load;
    logic [2:0] op;
    logic [2:0] count;
    logic [0:3] data;
  } cmd_t;

  // FIFO state
  cmd_t             mem_q [FIFO_DEPTH];
  cmd_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Sequencer state; rem_q counts shift steps still to emit after the one on S
  state_t     state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic [2:0] op_q, op_d;
  logic [2:0] s_q, s_d;
  logic [0:3] l_q, l_d;
  logic       done_q, done_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic start_next;
  cmd_t head;
  cmd_t incoming;

  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign cmd_ready = !full && !Reset;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  assign S    = s_q;
  assign L    = l_q;
  assign done = done_q;
  assign busy = (state_q != IDLE) || !empty;

  // Capture an incoming command; op 111 is stored as hold so a stale L is never reloaded
  always_comb begin
    incoming.load  = cmd_load;
    incoming.op    = (cmd_op == SEL_LOAD) ? SEL_HOLD : cmd_op;
    incoming.count = cmd_count;
    incoming.data  = cmd_data;
  end

  // Next-state and output decode: start a new command when idle or on a final step
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    op_d       = op_q;
    s_d        = s_q;
    l_d        = l_q;
    done_d     = 1'b0;
    start_next = 1'b0;

    case (state_q)
      IDLE:               start_next = 1'b1;
      LOADSTEP, SHIFTSTEP: start_next = (rem_q == 3'd0);
      default:            start_next = 1'b1;
    endcase

    if (start_next) begin
      if (!empty) begin
        op_d = head.op;
        if (head.load) begin
          state_d = LOADSTEP;
          s_d     = SEL_LOAD;
          l_d     = head.data;
          rem_d   = head.count;
          done_d  = (head.count == 3'd0);
        end else if (head.count == 3'd0) begin
          // Zero-length command still occupies one hold cycle
          state_d = SHIFTSTEP;
          s_d     = SEL_HOLD;
          rem_d   = 3'd0;
          done_d  = 1'b1;
        end else begin
          state_d = SHIFTSTEP;
          s_d     = head.op;
          rem_d   = head.count - 3'd1;
          done_d  = (head.count == 3'd1);
        end
      end else begin
        state_d = IDLE;
        s_d     = SEL_HOLD;
        rem_d   = 3'd0;
      end
    end else begin
      state_d = SHIFTSTEP;
      s_d     = op_q;
      rem_d   = rem_q - 3'd1;
      done_d  = (rem_q == 3'd1);
    end
  end

  assign pop = start_next && !empty;

  // FIFO bookkeeping: push and pop may coincide
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = incoming;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control and output registers; reset aborts any command and empties the FIFO
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      rem_q    <= 3'd0;
      op_q     <= SEL_HOLD;
      s_q      <= SEL_HOLD;
      l_q      <= 4'b0000;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      s_q      <= s_d;
      l_q      <= l_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Command storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge Clock) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: scoreboard of expected per-cycle steps,
// plus a behavioural model of the downstream 4-bit shifter.
module tb_shift_sequencer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [2:0] cmd_count;
  logic [0:3] cmd_data;
  logic [2:0] S;
  logic [0:3] L;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [2:0] s;
    logic [3:0] l;
    logic       d;
  } step_t;

  step_t      exp_q [$];
  step_t      mon_e;
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;
  logic [3:0] exp_l = 4'b0000;
  logic [3:0] q_model = 4'b0000;

  shift_sequencer #(.FIFO_DEPTH(2)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_load (cmd_load),
    .cmd_op   (cmd_op),
    .cmd_count(cmd_count),
    .cmd_data (cmd_data),
    .S        (S),
    .L        (L),
    .busy     (busy),
    .done     (done)
  );

  always #5 Clock = ~Clock;

  // Downstream shifter model: applies the select present during the previous cycle
  always @(posedge Clock) begin
    case (S)
      3'b001: q_model <= {q_model[0], q_model[3:1]};
      3'b010: q_model <= {q_model[2:0], q_model[3]};
      3'b011: q_model <= q_model >> 1;
      3'b100: q_model <= q_model << 1;
      3'b101: q_model <= {q_model[3], q_model[3:1]};
      3'b110: q_model <= q_model << 1;
      3'b111: q_model <= L;
      default: q_model <= q_model;
    endcase
  end

  // Scoreboard consumer: one expected step per cycle once armed
  always @(negedge Clock) begin
    if (mon_en && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if ({S, L, done} !== {mon_e.s, mon_e.l, mon_e.d}) begin
        miscompares++;
        $display("FAIL step: got S=%b L=%b done=%b, expected S=%b L=%b done=%b",
                 S, L, done, mon_e.s, mon_e.l, mon_e.d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected step stream of one command, derived from the command fields
  task automatic sb_push(input bit ld, input logic [2:0] op, input logic [2:0] cnt,
                         input logic [3:0] dat);
    logic [2:0] mop;
    mop = (op == 3'b111) ? 3'b000 : op;
    if (ld) begin
      exp_l = dat;
      exp_q.push_back('{s: 3'b111, l: dat, d: (cnt == 3'd0)});
    end else if (cnt == 3'd0) begin
      exp_q.push_back('{s: 3'b000, l: exp_l, d: 1'b1});
    end
    for (int i = 0; i < int'(cnt); i++) begin
      exp_q.push_back('{s: mop, l: exp_l, d: (i == int'(cnt) - 1)});
    end
  endtask

  // Present one command and hold it until accepted; returns cycles stalled
  task automatic send_cmd(input bit ld, input logic [2:0] op, input logic [2:0] cnt,
                          input logic [3:0] dat, output int waited);
    waited = 0;
    @(negedge Clock);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = dat;
    while (!cmd_ready && waited < 50) begin
      @(negedge Clock);
      waited++;
    end
    if (waited >= 50) begin
      miscompares++;
      $display("FAIL send_timeout: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, waited);
      cmd_valid = 1'b0;
    end else begin
      @(posedge Clock);
      #1 cmd_valid = 1'b0;
    end
  endtask

  // Wait for the scoreboard to empty; flushes and reports not-ok on timeout
  task automatic drain(output bit ok);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge Clock);
      #1;
      w++;
    end
    ok = (exp_q.size() == 0);
    if (!ok) exp_q.delete();
    mon_en = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_load = 1'b0;
    cmd_op = 3'b000;
    cmd_count = 3'd0;
    cmd_data = 4'b0000;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    vectors++;
    if (S !== 3'b000) begin miscompares++; $display("FAIL reset_S: got %b, expected 000", S); end
    vectors++;
    if (L !== 4'b0000) begin miscompares++; $display("FAIL reset_L: got %b, expected 0000", L); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", done); end
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, expected 0", cmd_ready); end
    Reset = 1'b0;
    exp_l = 4'b0000;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b, expected 1", cmd_ready); end
  endtask

  task automatic test_load_only;
    int w;
    bit ok;
    @(posedge Clock); #1;
    sb_push(1'b1, 3'b000, 3'd0, 4'b1011);
    send_cmd(1'b1, 3'b000, 3'd0, 4'b1011, w);
    @(posedge Clock); #1 mon_en = 1'b1;
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL load_only_drain: steps missing, expected all consumed"); end
    vectors++;
    if ({S, done, busy} !== 5'b0) begin miscompares++; $display("FAIL load_only_idle: got S=%b done=%b busy=%b, expected 000 0 0", S, done, busy); end
    vectors++;
    if (q_model !== 4'b1011) begin miscompares++; $display("FAIL load_only_Q: got %b, expected 1011", q_model); end
  endtask

  task automatic test_load_shift;
    int w;
    bit ok;
    @(posedge Clock); #1;
    sb_push(1'b1, 3'b100, 3'd3, 4'b0001);
    send_cmd(1'b1, 3'b100, 3'd3, 4'b0001, w);
    @(posedge Clock); #1 mon_en = 1'b1;
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL load_shift_drain: steps missing, expected all consumed"); end
    vectors++;
    if ({S, done, busy} !== 5'b0) begin miscompares++; $display("FAIL load_shift_idle: got S=%b done=%b busy=%b, expected 000 0 0", S, done, busy); end
    vectors++;
    if (q_model !== 4'b1000) begin miscompares++; $display("FAIL load_shift_Q: got %b, expected 1000", q_model); end
  endtask

  task automatic test_back_to_back;
    int w;
    bit ok;
    @(posedge Clock); #1;
    for (int i = 0; i < 3; i++) sb_push(1'b0, 3'b001, 3'd2, 4'b0000);
    fork
      begin
        send_cmd(1'b0, 3'b001, 3'd2, 4'b0000, w);
        send_cmd(1'b0, 3'b001, 3'd2, 4'b0000, w);
        send_cmd(1'b0, 3'b001, 3'd2, 4'b0000, w);
      end
      begin
        @(posedge Clock);
        @(posedge Clock);
        #1 mon_en = 1'b1;
        @(negedge Clock);
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_one_queued: got %b, expected 1", cmd_ready); end
        @(negedge Clock);
        vectors++;
        if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b, expected 0", cmd_ready); end
        @(negedge Clock);
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_pop: got %b, expected 1", cmd_ready); end
      end
    join
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_drain: steps missing, expected all consumed"); end
    vectors++;
    if ({S, done, busy} !== 5'b0) begin miscompares++; $display("FAIL b2b_idle: got S=%b done=%b busy=%b, expected 000 0 0", S, done, busy); end
    vectors++;
    if (q_model !== 4'b0010) begin miscompares++; $display("FAIL b2b_Q: got %b, expected 0010", q_model); end
  endtask

  task automatic test_op_remap;
    int w;
    bit ok;
    @(posedge Clock); #1;
    sb_push(1'b0, 3'b111, 3'd2, 4'b1111);
    send_cmd(1'b0, 3'b111, 3'd2, 4'b1111, w);
    @(posedge Clock); #1 mon_en = 1'b1;
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL remap_drain: steps missing, expected all consumed"); end
    vectors++;
    if (q_model !== 4'b0010) begin miscompares++; $display("FAIL remap_Q: got %b, expected 0010", q_model); end
  endtask

  task automatic test_full_stall;
    int w;
    int wd;
    bit ok;
    @(posedge Clock); #1;
    sb_push(1'b1, 3'b101, 3'd7, 4'b1000);
    sb_push(1'b0, 3'b011, 3'd1, 4'b0000);
    sb_push(1'b1, 3'b000, 3'd0, 4'b0110);
    sb_push(1'b0, 3'b010, 3'd1, 4'b0000);
    fork
      begin
        send_cmd(1'b1, 3'b101, 3'd7, 4'b1000, w);
        send_cmd(1'b0, 3'b011, 3'd1, 4'b0000, w);
        send_cmd(1'b1, 3'b000, 3'd0, 4'b0110, w);
        send_cmd(1'b0, 3'b010, 3'd1, 4'b0000, wd);
      end
      begin
        @(posedge Clock);
        @(posedge Clock);
        #1 mon_en = 1'b1;
      end
    join
    vectors++;
    if (wd == 0) begin miscompares++; $display("FAIL stall_held: 4th command waited %0d cycles, expected >0", wd); end
    drain(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stall_drain: steps missing, expected all consumed"); end
    vectors++;
    if ({S, done, busy} !== 5'b0) begin miscompares++; $display("FAIL stall_idle: got S=%b done=%b busy=%b, expected 000 0 0", S, done, busy); end
    vectors++;
    if (q_model !== 4'b1100) begin miscompares++; $display("FAIL stall_Q: got %b, expected 1100", q_model); end
  endtask

  task automatic test_reset_abort;
    int w;
    bit bad;
    @(posedge Clock); #1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{s: 3'b101, l: exp_l, d: 1'b0});
    send_cmd(1'b0, 3'b101, 3'd7, 4'b0000, w);
    send_cmd(1'b0, 3'b001, 3'd1, 4'b0000, w);
    mon_en = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready_in_reset: got %b, expected 0", cmd_ready); end
    @(posedge Clock); #1;
    mon_en = 1'b0;
    exp_l = 4'b0000;
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL abort_steps_seen: %0d steps unobserved, expected 0", exp_q.size()); exp_q.delete(); end
    vectors++;
    if ({S, done, busy} !== 5'b0) begin miscompares++; $display("FAIL abort_outputs: got S=%b done=%b busy=%b, expected 000 0 0", S, done, busy); end
    vectors++;
    if (L !== 4'b0000) begin miscompares++; $display("FAIL abort_L: got %b, expected 0000", L); end
    @(negedge Clock);
    Reset = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge Clock);
      if (S !== 3'b000 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL abort_quiet: activity after reset, last S=%b done=%b busy=%b, expected 000 0 0", S, done, busy); end
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_load_shift();
    test_back_to_back();
    test_op_remap();
    test_full_stall();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
